frame_capture: RTL and testbench
================================

Name: frame_capture

Overview:
- Receiving end of the pixel stream produced by the team's frame generator.
- Consumes a raster of 24-bit RGB pixels qualified by dval and delimited by sof/eol.
- Checks frame geometry, stores one complete frame in on-chip RAM, and exposes a read port so checkers and downstream stages can fetch pixels after frame_done.
- Sits at the output of the resize/processing datapath, ahead of the result dumper.

Parameters:
- NX, 349, pixels per line.
- NY, 349, lines per frame.
- AW, clogb2(NX*NY), RAM address width (derived localparam, not overridable).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sof  in  1  start of frame; valid only with dval; marks pixel (0,0).
- eol  in  1  end of line; valid only with dval; marks pixel NX-1 of each line.
- dval  in  1  pixel qualifier; one pixel per cycle when high.
- pixel  in  24  {R[23:16], G[15:8], B[7:0]}.
- rd_addr  in  AW  read address = line*NX + column.
- rd_data  out  24  registered read data.
- busy  out  1  frame capture in progress.
- frame_done  out  1  one-cycle pulse: a complete, error-free frame is stored.
- frame_err  out  1  sticky geometry error; cleared by the next accepted sof.
- frame_cnt  out  16  count of good frames, wraps at 2^16.

Behaviour:
- Reset (synchronous, active-high; clock clk): state=IDLE; busy=0, frame_done=0, frame_err=0, frame_cnt=0, rd_data=0; column/line/write-address counters=0. RAM contents are not reset.
- sof or eol with dval=0 is ignored. Cycles with dval=0 never advance counters.
- Write address is a running counter incremented per accepted pixel. No multiplier.
- State IDLE:
  - dval&sof: write pixel at addr 0; col=1, line=0; clear frame_err; go ACTIVE; busy=1 from next cycle.
  - Pixels without sof are discarded.
  - NX=1: the first pixel must also carry eol, else error.
- State ACTIVE, accepted pixel (dval=1), checks in priority order:
  - sof: error (frame_err=1), then resync. The pixel is written at addr 0; the frame restarts at col=1, line=0; stay ACTIVE.
  - eol with col!=NX-1: short-line error. frame_err=1; go IDLE; pixel not written.
  - col==NX-1 without eol: long-line error. frame_err=1; go IDLE; pixel not written.
  - eol with col==NX-1 and line<NY-1: write; col=0, line+1.
  - eol with col==NX-1 and line==NY-1: write; go DONE.
  - otherwise: write; col+1.
- State DONE (one cycle):
  - frame_done=1, frame_cnt+1, busy=0; go IDLE.
  - dval&sof in this cycle is treated as the IDLE sof, so back-to-back frames capture without a gap.
- sof-driven clearing of frame_err happens in the same edge that accepts sof, including the resync case. Net effect of a mid-frame sof: frame_err=1, then cleared. frame_err is therefore visible for exactly one cycle — intentional; the bench checks it.
- Read port:
  - rd_data <= RAM[rd_addr] every cycle, latency 1.
  - Reads are allowed at any time.
  - Same-address read/write in one cycle returns the old data (read-before-write).
  - rd_addr >= NX*NY returns 0.
- Reset mid-frame aborts capture immediately. Already-written RAM words remain; no frame_done.

Decomposition:
- Shared package (frame_pkg):
  - clogb2 function.
  - State encoding constants: IDLE=2'd0, ACTIVE=2'd1, DONE=2'd2.
  - Pixel width constant PIX_W=24.
- Sub-module frame_capture_ram:
  - Simple dual-port, 1 write / 1 registered read.
  - Depth NX*NY, width 24, read-before-write.
  - Out-of-range read returns 0.
- Top: FSM, counters, checks.

Test Plan (NX=4, NY=3 unless stated):
- Clean frame: 12 pixels, values 0x000001..0x00000C, sof on the first, eol on pixels 4/8/12 -> frame_done pulses once, one cycle after the 12th pixel; frame_cnt=1; rd_addr 0..11 returns 0x000001..0x00000C with 1-cycle latency.
- dval gaps: same frame with dval low every other cycle -> identical RAM contents; frame_done one cycle after the last valid pixel.
- Short line: eol on the 3rd pixel of line 1 -> frame_err=1, busy=0, no frame_done. The next clean frame clears frame_err at its sof and completes; frame_cnt=1.
- Long line: no eol on the 4th pixel -> frame_err=1, return to IDLE; the 4th pixel is not written (addr 3 keeps its prior value).
- Mid-frame sof at pixel 6 carrying 0xAA0000 -> frame_err pulses high for one cycle; RAM[0]=0xAA0000; the frame then completes 11 pixels later with frame_done.
- Back-to-back frames: sof in the DONE cycle -> second frame captured without a gap; frame_cnt=2. Assert rst during the third frame -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/frame_pkg.sv
// frame_pkg: shared types, constants and helpers for the frame capture block.
//   PIX_W   - pixel width ({R,G,B} x 8 bits)
//   state_t - capture FSM state encoding
//   clogb2  - ceil(log2(n)), at least 1, for sizing counters and addresses
package frame_pkg;
    localparam int PIX_W = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic int clogb2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/frame_capture_ram.sv
// frame_capture_ram: simple dual-port frame store, one write port and one
// registered read port (read-before-write, out-of-range reads return 0).
//   clk, rst  - clock / synchronous active-high reset (clears rd_data only)
//   we, waddr, wdata - write port
//   raddr     - read address, rd_data valid one cycle later
module frame_capture_ram
    import frame_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [PIX_W-1:0] rd_data
);
    logic [PIX_W-1:0] mem [DEPTH];
    logic             in_range;

    // Extra bit so the compare also works when DEPTH == 2**AW.
    assign in_range = {1'b0, raddr} < (AW + 1)'(DEPTH);

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data <= '0;
        else     rd_data <= in_range ? mem[raddr] : '0;
    end
endmodule

// File: rtl/frame_capture.sv
// frame_capture: receives a dval-qualified sof/eol-delimited RGB raster,
// checks its geometry and stores one full frame for later readback.
//   clk, rst          - clock / synchronous active-high reset
//   sof, eol, dval    - stream framing and pixel qualifier
//   pixel             - {R,G,B} pixel data
//   rd_addr, rd_data  - readback port (line*NX+column), 1-cycle latency
//   busy              - capture in progress
//   frame_done        - one-cycle pulse per good frame
//   frame_err         - sticky geometry error, cleared by next accepted sof
//   frame_cnt         - good frame count (wrapping)
module frame_capture
    import frame_pkg::*;
#(
    parameter int  NX = 349,
    parameter int  NY = 349,
    localparam int AW = clogb2(NX * NY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof,
    input  logic             eol,
    input  logic             dval,
    input  logic [PIX_W-1:0] pixel,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_data,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_err,
    output logic [15:0]      frame_cnt
);
    localparam int CW = clogb2(NX);
    localparam int LW = clogb2(NY);

    state_t        state, state_n;
    logic [CW-1:0] col, col_n, cur_col;
    logic [LW-1:0] line, line_n, cur_line;
    logic [AW-1:0] waddr, waddr_n, cur_addr;
    logic          start, resync, take, short_e, long_e, err, we, clr_pend;

    // A sof pixel is checked exactly like any other pixel, just at (0,0),
    // which also covers the single-column case (first pixel needs eol).
    always_comb begin
        start    = dval && sof;
        resync   = start && (state == ACTIVE);
        take     = dval && (start || state == ACTIVE);
        cur_col  = start ? '0 : col;
        cur_line = start ? '0 : line;
        cur_addr = start ? '0 : waddr;
        short_e  = eol && (cur_col != CW'(NX - 1));
        long_e   = !eol && (cur_col == CW'(NX - 1));
        err      = take && (short_e || long_e);
        we       = take && !err && !rst;
        state_n  = (state == ACTIVE) ? ACTIVE : IDLE;
        col_n    = col;
        line_n   = line;
        waddr_n  = waddr;
        if (take) begin
            state_n = err ? IDLE : (eol && cur_line == LW'(NY - 1)) ? DONE : ACTIVE;
            col_n   = eol ? '0 : cur_col + CW'(1);
            line_n  = eol ? cur_line + LW'(1) : cur_line;
            waddr_n = cur_addr + AW'(1);
        end
    end

    // A resync sof raises frame_err for one cycle; clr_pend drops it on the
    // following edge unless a new error arrives then.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            line       <= '0;
            waddr      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
            clr_pend   <= 1'b0;
        end else begin
            state      <= state_n;
            col        <= col_n;
            line       <= line_n;
            waddr      <= waddr_n;
            busy       <= state_n == ACTIVE;
            frame_done <= state_n == DONE;
            frame_cnt  <= frame_cnt + {15'd0, state_n == DONE};
            frame_err  <= (err || resync) ? 1'b1 : (start || clr_pend) ? 1'b0 : frame_err;
            clr_pend   <= resync;
        end
    end

    frame_capture_ram #(.DEPTH(NX * NY), .AW(AW)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (cur_addr),
        .wdata   (pixel),
        .raddr   (rd_addr),
        .rd_data (rd_data)
    );
endmodule

// File: tb/tb_frame_capture.sv
// tb_frame_capture: directed self-checking bench for frame_capture (4x3 frame).
module tb_frame_capture;
    localparam int NX = 4;
    localparam int NY = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sof = 1'b0;
    logic        eol = 1'b0;
    logic        dval = 1'b0;
    logic [23:0] pixel = '0;
    logic [3:0]  rd_addr = '0;
    logic [23:0] rd_data;
    logic        busy, frame_done, frame_err;
    logic [15:0] frame_cnt;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    frame_capture #(.NX(NX), .NY(NY)) dut (
        .clk        (clk),
        .rst        (rst),
        .sof        (sof),
        .eol        (eol),
        .dval       (dval),
        .pixel      (pixel),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then return at the following falling edge.
    task automatic step(input logic v, input logic s, input logic e, input logic [23:0] p);
        dval = v; sof = s; eol = e; pixel = p;
        @(posedge clk);
        @(negedge clk);
        dval = 1'b0; sof = 1'b0; eol = 1'b0;
    endtask

    task automatic px(input logic [23:0] base, input int k, input logic s);
        step(1'b1, s, (k % NX) == NX - 1, base + 24'(k));
    endtask

    task automatic rd(input int a, input logic [23:0] exp);
        rd_addr = 4'(a);
        step(1'b0, 1'b0, 1'b0, 24'h0);
        chk($sformatf("rd[%0d]", a), {8'h0, rd_data}, {8'h0, exp});
    endtask

    task automatic stat(input string tag, input logic b, input logic d, input logic e, input int c);
        chk({tag, ".busy"}, {31'h0, busy}, {31'h0, b});
        chk({tag, ".done"}, {31'h0, frame_done}, {31'h0, d});
        chk({tag, ".err"}, {31'h0, frame_err}, {31'h0, e});
        chk({tag, ".cnt"}, {16'h0, frame_cnt}, 32'(c));
    endtask

    initial begin
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        stat("reset", 0, 0, 0, 0);
        chk("reset.rd_data", {8'h0, rd_data}, 32'h0);
        rst = 1'b0;

        // clean frame 1..12
        for (int k = 0; k < 12; k++) begin
            px(24'h1, k, k == 0);
            if (k == 0) chk("clean.busy0", {31'h0, busy}, 32'h1);
            if (k == 10) chk("clean.early_done", {31'h0, frame_done}, 32'h0);
        end
        stat("clean", 0, 1, 0, 1);
        step(0, 0, 0, 0);
        chk("clean.pulse", {31'h0, frame_done}, 32'h0);
        for (int i = 0; i < 12; i++) rd(i, 24'(i + 1));
        rd(12, 24'h0);
        rd(15, 24'h0);

        // dval gaps
        for (int k = 0; k < 12; k++) begin
            px(24'h100, k, k == 0);
            if (k != 11) step(0, 0, 0, 24'hFFFFFF);
        end
        stat("gaps", 0, 1, 0, 2);
        for (int i = 0; i < 12; i++) rd(i, 24'h100 + 24'(i));

        // short line: eol on 3rd pixel of line 1
        for (int k = 0; k < 6; k++) px(24'h200, k, k == 0);
        step(1, 0, 1, 24'h206);
        stat("short", 0, 0, 1, 2);
        step(0, 0, 0, 0);
        chk("short.sticky", {31'h0, frame_err}, 32'h1);
        rd(6, 24'h106);
        rd(5, 24'h205);
        px(24'h300, 0, 1);
        chk("short.clr", {31'h0, frame_err}, 32'h0);
        for (int k = 1; k < 12; k++) px(24'h300, k, 0);
        stat("recover", 0, 1, 0, 3);

        // long line: 4th pixel without eol
        for (int k = 0; k < 3; k++) px(24'h400, k, k == 0);
        step(1, 0, 0, 24'h403);
        stat("long", 0, 0, 1, 3);
        rd(3, 24'h303);
        rd(2, 24'h402);

        // mid-frame sof at pixel 6
        for (int k = 0; k < 5; k++) px(24'h500, k, k == 0);
        chk("mid.pre_err", {31'h0, frame_err}, 32'h0);
        step(1, 1, 0, 24'hAA0000);
        chk("mid.err_hi", {31'h0, frame_err}, 32'h1);
        chk("mid.busy", {31'h0, busy}, 32'h1);
        px(24'h600, 1, 0);
        chk("mid.err_lo", {31'h0, frame_err}, 32'h0);
        for (int k = 2; k < 12; k++) px(24'h600, k, 0);
        stat("mid", 0, 1, 0, 4);
        rd(0, 24'hAA0000);
        rd(1, 24'h601);
        rd(11, 24'h60B);

        // back-to-back frames, sof in the DONE cycle
        for (int k = 0; k < 12; k++) px(24'h700, k, k == 0);
        stat("b2b_a", 0, 1, 0, 5);
        px(24'h800, 0, 1);
        stat("b2b_sof", 1, 0, 0, 5);
        for (int k = 1; k < 12; k++) px(24'h800, k, 0);
        stat("b2b_b", 0, 1, 0, 6);
        rd(0, 24'h800);
        rd(11, 24'h80B);

        // reset during third frame
        for (int k = 0; k < 4; k++) px(24'h900, k, k == 0);
        chk("rst3.busy_pre", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        step(1, 0, 0, 24'h904);
        stat("rst3", 0, 0, 0, 0);
        chk("rst3.rd_data", {8'h0, rd_data}, 32'h0);
        rst = 1'b0;
        rd(0, 24'h900);
        rd(4, 24'h804);
        chk("rst3.no_done", {31'h0, frame_done}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
